mem_miss_arbiter: RTL and testbench

- Sequences the single shared multi-cycle main memory on behalf of the instruction-cache miss path and the data-cache miss and write-through paths.
- Arbitrates between three requesters:
  - 8-word block refills for the I-cache.
  - 8-word block refills for the D-cache.
  - Single-word write-through stores from the D-cache.
- Streams refill words back to the owning cache, then signals completion.
- Sits between the IF/MEM-stage caches and the main memory model. Pipeline stalls are held by the caches while their request is pending.

---
 rtl/mem_miss_arbiter_if.sv | 59 +++++
 rtl/mem_miss_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_miss_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_miss_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_miss_arbiter_if
//  Purpose  : Bundles the cache-request, main-memory and refill signals of
//             the miss arbiter.
//  Modports : slave  - arbiter view (requests and memory read data in,
//                      memory strobes, refill and handshake pulses out)
//             master - requester/memory view (mirror of slave)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_miss_arbiter_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
);
  // cache requests
  logic              i_miss;
  logic [AWIDTH-1:0] i_miss_addr;
  logic              d_miss;
  logic [AWIDTH-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [AWIDTH-1:0] d_wr_addr;
  logic [DWIDTH-1:0] d_wr_data;
  // main memory
  logic              mem_en;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_data_out;
  logic [DWIDTH-1:0] mem_data_in;
  logic              mem_data_valid;
  // refill path and completion handshakes
  logic              fill_owner;
  logic              fill_we;
  logic [AWIDTH-1:0] fill_addr;
  logic [DWIDTH-1:0] fill_data;
  logic              fill_tag_we;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_ack;
  logic              busy;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_in, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_data_out,
    output fill_owner, fill_we, fill_addr, fill_data, fill_tag_we,
    output i_fill_done, d_fill_done, d_wr_ack, busy
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_in, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_data_out,
    input  fill_owner, fill_we, fill_addr, fill_data, fill_tag_we,
    input  i_fill_done, d_fill_done, d_wr_ack, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_miss_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_miss_arbiter
//  Purpose  : Sequences the shared, pipelined main memory for I-cache block
//             refills, D-cache block refills and D-cache write-through
//             stores. Fixed priority d_miss > d_wr_req > i_miss, sampled only
//             when idle; no preemption.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous, active-low reset
//             bus  - mem_miss_arbiter_if.slave (requests, memory, refill)
//  Revision : 1.0  initial release
// ============================================================================
module mem_miss_arbiter #(
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 16,
  parameter int WORDS       = 8,
  parameter int MEM_LATENCY = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mem_miss_arbiter_if.slave  bus
);

  localparam int                c_CW         = $clog2(WORDS) + 1;
  localparam logic [AWIDTH-1:0] c_BLOCK_MASK = ~AWIDTH'(2 * WORDS - 1);
  localparam logic [AWIDTH-1:0] c_HALF_MASK  = ~AWIDTH'(1);

  // The refill sequencing assumes a power-of-two block and a memory that
  // takes at least one cycle to answer.
  generate
    if (MEM_LATENCY < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_params
      $error("mem_miss_arbiter: WORDS must be a power of two >= 2 and MEM_LATENCY >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_WRITE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_base;
  logic [c_CW-1:0]   r_issue_cnt;   // index of the read currently on the bus
  logic [c_CW-1:0]   r_recv_cnt;    // words already returned by memory
  logic              r_fill_owner;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_data_out;
  logic              r_fill_tag_we;
  logic              r_i_fill_done;
  logic              r_d_fill_done;
  logic              r_d_wr_ack;

  function automatic logic [AWIDTH-1:0] word_addr(input logic [AWIDTH-1:0] base,
                                                  input logic [c_CW-1:0]   idx);
    return base + (AWIDTH'(idx) << 1);
  endfunction

  logic              w_grant_fill;
  logic [AWIDTH-1:0] w_req_base;
  logic [c_CW-1:0]   w_issue_next;
  logic              w_fill_we;

  assign w_grant_fill = bus.d_miss || (!bus.d_wr_req && bus.i_miss);
  assign w_req_base   = (bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & c_BLOCK_MASK;
  assign w_issue_next = r_issue_cnt + c_CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_base         <= '0;
      r_issue_cnt    <= '0;
      r_recv_cnt     <= '0;
      r_fill_owner   <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data_out <= '0;
      r_fill_tag_we  <= 1'b0;
      r_i_fill_done  <= 1'b0;
      r_d_fill_done  <= 1'b0;
      r_d_wr_ack     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Outputs are registered, so the first read or the store is put on
          // the bus by the grant itself and appears in the next cycle.
          if (w_grant_fill) begin
            r_state      <= ST_FILL;
            r_base       <= w_req_base;
            r_fill_owner <= bus.d_miss;
            r_issue_cnt  <= '0;
            r_recv_cnt   <= '0;
            r_mem_en     <= 1'b1;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= w_req_base;
          end else if (bus.d_wr_req) begin
            r_state        <= ST_WRITE;
            r_fill_owner   <= 1'b0;
            r_mem_en       <= 1'b1;
            r_mem_wr       <= 1'b1;
            r_mem_addr     <= bus.d_wr_addr & c_HALF_MASK;
            r_mem_data_out <= bus.d_wr_data;
            r_d_wr_ack     <= 1'b1;
          end
        end

        ST_FILL: begin
          if (r_mem_en) begin
            r_issue_cnt <= w_issue_next;
            if (w_issue_next < c_CW'(WORDS)) begin
              r_mem_addr <= word_addr(r_base, w_issue_next);
            end else begin
              r_mem_en   <= 1'b0;
              r_mem_addr <= '0;
            end
          end
          if (bus.mem_data_valid) begin
            r_recv_cnt <= r_recv_cnt + c_CW'(1);
            if (r_recv_cnt == c_CW'(WORDS - 1)) begin
              r_state       <= ST_COMPLETE;
              r_mem_en      <= 1'b0;
              r_mem_addr    <= '0;
              r_fill_tag_we <= 1'b1;
              r_i_fill_done <= !r_fill_owner;
              r_d_fill_done <= r_fill_owner;
            end
          end
        end

        ST_COMPLETE: begin
          r_state       <= ST_IDLE;
          r_fill_owner  <= 1'b0;
          r_fill_tag_we <= 1'b0;
          r_i_fill_done <= 1'b0;
          r_d_fill_done <= 1'b0;
        end

        ST_WRITE: begin
          r_state        <= ST_IDLE;
          r_mem_en       <= 1'b0;
          r_mem_wr       <= 1'b0;
          r_mem_addr     <= '0;
          r_mem_data_out <= '0;
          r_d_wr_ack     <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Refill writes follow mem_data_valid in the same cycle, so this path is
  // combinational; the state gate keeps stray valids in IDLE harmless.
  assign w_fill_we = (r_state == ST_FILL) && bus.mem_data_valid;

  assign bus.fill_we      = w_fill_we;
  assign bus.fill_data    = w_fill_we ? bus.mem_data_in : '0;
  assign bus.fill_addr    = w_fill_we                  ? word_addr(r_base, r_recv_cnt) :
                            (r_state == ST_COMPLETE)   ? r_base : '0;
  assign bus.fill_owner   = r_fill_owner;
  assign bus.fill_tag_we  = r_fill_tag_we;
  assign bus.i_fill_done  = r_i_fill_done;
  assign bus.d_fill_done  = r_d_fill_done;
  assign bus.d_wr_ack     = r_d_wr_ack;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_data_out = r_mem_data_out;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_miss_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_miss_arbiter
//  Purpose  : Directed bench for mem_miss_arbiter with a pipelined memory
//             model, a transaction-level expectation model compared every
//             cycle, and hand-computed literal expectations per scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_miss_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int WORDS = 8;
  localparam int ML    = 4;
  localparam logic [AW-1:0] c_MASK = ~AW'(2 * WORDS - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_miss_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_miss_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .WORDS(WORDS), .MEM_LATENCY(ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory pipeline: reads return in order, ML cycles after issue
  typedef struct { logic [AW-1:0] addr; int due; } rd_t;
  rd_t mq[$];

  // event logs
  logic [AW-1:0] q_fa[$];
  logic [DW-1:0] q_fd[$];
  bit            q_fo[$];
  logic [AW-1:0] q_rd[$];
  int t_idone = -1, t_ddone = -1, t_tag = -1, t_ack = -1, n_done = 0;
  logic [AW-1:0] ack_addr;
  logic [DW-1:0] ack_data;
  logic          ack_wr;

  // transaction model: one operation at a time, timed by cycles since grant
  bit            m_busy = 0, m_fill = 0, m_owner = 0;
  int            m_k = 0, m_recv = 0;
  logic [AW-1:0] m_base = '0, m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic          e_en, e_wr, e_we, e_tag, e_id, e_dd, e_ack, e_busy, e_own;
    logic [AW-1:0] e_addr, e_fa;
    logic [DW-1:0] e_fd, e_do;
    e_en = 0; e_wr = 0; e_we = 0; e_tag = 0; e_id = 0; e_dd = 0; e_ack = 0;
    e_busy = 0; e_own = 0; e_addr = '0; e_fa = '0; e_fd = '0; e_do = '0;
    if (m_busy) begin
      e_busy = 1;
      if (m_fill) begin
        e_own = m_owner;
        if (m_k <= WORDS) begin
          e_en   = 1;
          e_addr = m_base + AW'(2 * (m_k - 1));
        end
        if (m_k <= WORDS + ML && bus.mem_data_valid) begin
          e_we = 1;
          e_fa = m_base + AW'(2 * m_recv);
          e_fd = bus.mem_data_in;
        end
        if (m_k == WORDS + ML + 1) begin
          e_tag = 1;
          e_fa  = m_base;
          e_id  = !m_owner;
          e_dd  = m_owner;
        end
      end else begin
        e_en = 1; e_wr = 1; e_addr = m_waddr; e_do = m_wdata; e_ack = 1;
      end
    end
    chk("busy",         bus.busy,         e_busy);
    chk("mem_en",       bus.mem_en,       e_en);
    chk("mem_wr",       bus.mem_wr,       e_wr);
    chk("mem_addr",     bus.mem_addr,     e_addr);
    chk("mem_data_out", bus.mem_data_out, e_do);
    chk("fill_owner",   bus.fill_owner,   e_own);
    chk("fill_we",      bus.fill_we,      e_we);
    chk("fill_addr",    bus.fill_addr,    e_fa);
    chk("fill_data",    bus.fill_data,    e_fd);
    chk("fill_tag_we",  bus.fill_tag_we,  e_tag);
    chk("i_fill_done",  bus.i_fill_done,  e_id);
    chk("d_fill_done",  bus.d_fill_done,  e_dd);
    chk("d_wr_ack",     bus.d_wr_ack,     e_ack);

    // logging of observed DUT activity
    if (bus.fill_we) begin
      q_fa.push_back(bus.fill_addr); q_fd.push_back(bus.fill_data); q_fo.push_back(bus.fill_owner);
    end
    if (bus.mem_en && !bus.mem_wr) q_rd.push_back(bus.mem_addr);
    if (bus.fill_tag_we) t_tag = cyc;
    if (bus.i_fill_done) begin t_idone = cyc; n_done++; end
    if (bus.d_fill_done) begin t_ddone = cyc; n_done++; end
    if (bus.d_wr_ack) begin
      t_ack = cyc; ack_addr = bus.mem_addr; ack_data = bus.mem_data_out; ack_wr = bus.mem_wr;
    end

    // advance the model to the next cycle
    if (!rst) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (m_fill && m_k <= WORDS + ML && bus.mem_data_valid) m_recv++;
      m_k++;
      if (m_fill ? (m_k > WORDS + ML + 1) : (m_k > 1)) m_busy = 0;
    end else if (bus.d_miss) begin
      m_busy = 1; m_fill = 1; m_owner = 1; m_base = bus.d_miss_addr & c_MASK; m_k = 1; m_recv = 0;
    end else if (bus.d_wr_req) begin
      m_busy = 1; m_fill = 0; m_waddr = bus.d_wr_addr & ~AW'(1); m_wdata = bus.d_wr_data; m_k = 1;
    end else if (bus.i_miss) begin
      m_busy = 1; m_fill = 1; m_owner = 0; m_base = bus.i_miss_addr & c_MASK; m_k = 1; m_recv = 0;
    end

    // memory accepts the read issued this cycle
    if (rst && bus.mem_en && !bus.mem_wr) mq.push_back('{bus.mem_addr, cyc + ML});

    // requesters drop their level once they see their handshake
    if (bus.i_fill_done) bus.i_miss = 0;
    if (bus.d_fill_done) bus.d_miss = 0;
    if (bus.d_wr_ack)    bus.d_wr_req = 0;
  endtask

  task automatic mem_drive();
    if (!rst) begin
      bus.mem_data_valid = 0; bus.mem_data_in = '0;
    end else if (mq.size() > 0 && mq[0].due == cyc) begin
      bus.mem_data_valid = 1; bus.mem_data_in = memf(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.mem_data_valid = 0; bus.mem_data_in = DW'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    mem_drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    bit idle = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
      idle = !bus.i_miss && !bus.d_miss && !bus.d_wr_req && !bus.busy;
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required idle", bus.busy, n);
    end
  endtask

  initial begin
    int t0, nf, nr, sw, nd;
    bus.i_miss = 0; bus.i_miss_addr = '0; bus.d_miss = 0; bus.d_miss_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.mem_data_valid = 0; bus.mem_data_in = '0;
    #1 rst = 0;
    tick(); tick();
    chk("reset_busy",   bus.busy,   0);
    chk("reset_mem_en", bus.mem_en, 0);
    rst = 1;

    // I-cache miss at 0x0136
    nf = q_fa.size(); nr = q_rd.size();
    bus.i_miss = 1; bus.i_miss_addr = 16'h0136; t0 = cyc;
    run_until_idle(40);
    chk("i_reads",      q_rd.size() - nr, 8);
    chk("i_rd_first",   q_rd[nr],         16'h0130);
    chk("i_rd_last",    q_rd[nr+7],       16'h013E);
    chk("i_fills",      q_fa.size() - nf, 8);
    chk("i_fill0_addr", q_fa[nf],         16'h0130);
    chk("i_fill0_data", q_fd[nf],         16'h6A5B);
    chk("i_fill7_addr", q_fa[nf+7],       16'h013E);
    chk("i_fill7_data", q_fd[nf+7],       16'h645B);
    chk("i_fill_owner", q_fo[nf],         0);
    chk("i_done_lat",   t_idone - t0,     13);
    chk("i_tag_cycle",  t_tag,            t_idone);

    // simultaneous D and I misses: D first, then I, no interleave
    nf = q_fa.size();
    bus.d_miss = 1; bus.d_miss_addr = 16'h2008;
    bus.i_miss = 1; bus.i_miss_addr = 16'h0040;
    run_until_idle(80);
    chk("di_fills",     q_fa.size() - nf, 16);
    chk("di_first_own", q_fo[nf],         1);
    chk("di_d_addr",    q_fa[nf],         16'h2000);
    chk("di_d_data",    q_fd[nf],         16'h5A7A);
    chk("di_i_addr",    q_fa[nf+8],       16'h0040);
    chk("di_i_own",     q_fo[nf+8],       0);
    sw = 0;
    for (int i = nf + 1; i < q_fo.size(); i++) if (q_fo[i] != q_fo[i-1]) sw++;
    chk("di_switches",  sw,               1);
    chk("di_gap",       t_idone - t_ddone, 14);

    // write-through store while idle
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h1235; bus.d_wr_data = 16'hBEEF; t0 = cyc;
    run_until_idle(10);
    chk("wr_ack_lat",   t_ack - t0, 1);
    chk("wr_addr",      ack_addr,   16'h1234);
    chk("wr_data",      ack_data,   16'hBEEF);
    chk("wr_is_write",  ack_wr,     1);
    chk("wr_idle_next", cyc - t_ack, 1);

    // store miss: fill first, store on the IDLE cycle after COMPLETE
    bus.d_miss = 1; bus.d_miss_addr = 16'h3000;
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h3004; bus.d_wr_data = 16'h1111;
    run_until_idle(40);
    chk("sm_ack_after", t_ack - t_ddone, 2);

    // store requested mid I-fill
    bus.i_miss = 1; bus.i_miss_addr = 16'h0500;
    tick(); tick(); tick(); tick();
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h0A02; bus.d_wr_data = 16'h1357;
    run_until_idle(40);
    chk("mid_ack_after", t_ack - t_idone, 2);
    chk("mid_wr_addr",   ack_addr,        16'h0A02);

    // reset pulsed mid-fill after three words
    nf = q_fa.size(); nd = n_done;
    bus.i_miss = 1; bus.i_miss_addr = 16'h0300;
    t0 = 0;
    while (q_fa.size() - nf < 3 && t0 < 30) begin tick(); t0++; end
    if (q_fa.size() - nf < 3) begin
      checks++; errors++;
      $display("FAIL rst_wait: got %0d fills, required 3", q_fa.size() - nf);
    end
    #2 rst = 0;
    #1;
    chk("rst_busy",    bus.busy,        0);
    chk("rst_mem_en",  bus.mem_en,      0);
    chk("rst_addr",    bus.mem_addr,    0);
    chk("rst_fill_we", bus.fill_we,     0);
    chk("rst_tag",     bus.fill_tag_we, 0);
    chk("rst_owner",   bus.fill_owner,  0);
    m_busy = 0; mq.delete(); bus.i_miss = 0;
    bus.mem_data_valid = 0;
    tick(); tick();
    chk("rst_no_done", n_done - nd, 0);
    rst = 1;

    // block at the top of the address space
    nf = q_fa.size();
    bus.d_miss = 1; bus.d_miss_addr = 16'hFFF4; t0 = cyc;
    run_until_idle(40);
    chk("top_fills",     q_fa.size() - nf, 8);
    chk("top_first",     q_fa[nf],         16'hFFF0);
    chk("top_last",      q_fa[nf+7],       16'hFFFE);
    chk("top_last_data", q_fd[nf+7],       16'hA4A5);
    chk("top_owner",     q_fo[nf],         1);
    chk("top_done_lat",  t_ddone - t0,     13);

    // stray mem_data_valid in IDLE
    nf = q_fa.size();
    bus.mem_data_valid = 1; bus.mem_data_in = 16'h7777;
    tick();
    chk("stray_no_fill", q_fa.size() - nf, 0);
    chk("stray_busy",    bus.busy,         0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
